// File: rtl/wb_ascon_fifo_regif.sv
// Wishbone slave front-end for the ASCON core: control/key/nonce/tag registers plus block FIFOs.
// Define ASCON_REGIF_IRQ_EN to add the irq_o output and the IRQ register at word 17.
module wb_ascon_fifo_regif #(
  parameter int unsigned BLOCK_W   = 64,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic [31:0]        wb_dat_o,
  input  logic [2:0]         core_state,
  output logic               start,
  output logic [1:0]         mode,
  output logic [4:0]         ad_len,
  output logic [6:0]         data_len,
  output logic [127:0]       key,
  output logic [127:0]       nonce,
  output logic [BLOCK_W-1:0] in_blk,
  output logic               in_valid,
  input  logic               in_ready,
  input  logic [BLOCK_W-1:0] ct_blk,
  input  logic               ct_valid,
  input  logic [127:0]       tag,
  input  logic               tag_valid
`ifdef ASCON_REGIF_IRQ_EN
  ,
  output logic               irq_o
`endif
);

  localparam int unsigned WPB = BLOCK_W / 32;
  localparam int unsigned WCW = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned IAW = $clog2(IN_DEPTH);
  localparam int unsigned OAW = $clog2(OUT_DEPTH);
  localparam int unsigned ICW = IAW + 1;
  localparam int unsigned OCW = OAW + 1;

  logic               ack_q, ack_d, err_q, err_d;
  logic [31:0]        dat_q, dat_d;
  logic               start_q, start_d;
  logic [1:0]         mode_q, mode_d;
  logic [4:0]         ad_len_q, ad_len_d;
  logic [6:0]         data_len_q, data_len_d;
  logic [127:0]       key_q, key_d, nonce_q, nonce_d, tag_q, tag_d;
  logic               tag_rdy_q, tag_rdy_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [BLOCK_W-1:0] in_mem_q [IN_DEPTH];
  logic [BLOCK_W-1:0] in_mem_d [IN_DEPTH];
  logic [IAW-1:0]     in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [ICW-1:0]     in_cnt_q, in_cnt_d;
  logic [BLOCK_W-1:0] in_asm_q, in_asm_d;
  logic [WCW-1:0]     in_wcnt_q, in_wcnt_d;

  logic [BLOCK_W-1:0] out_mem_q [OUT_DEPTH];
  logic [BLOCK_W-1:0] out_mem_d [OUT_DEPTH];
  logic [OAW-1:0]     out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [OCW-1:0]     out_cnt_q, out_cnt_d;
  logic [WCW-1:0]     out_rcnt_q, out_rcnt_d;

  logic               wb_req_c, err_c, flush_c;
  logic [4:0]         adr_c;
  logic [1:0]         widx_c;
  logic [31:0]        bmask_c, rdata_c, status_c, ctrl_c, out_word_c;
  logic [BLOCK_W-1:0] out_head_c, in_push_blk_c;
  logic               in_full_c, in_empty_c, out_full_c, out_empty_c;
  logic               in_push_c, in_pop_c, out_push_c, out_pop_c;

`ifdef ASCON_REGIF_IRQ_EN
  logic [3:0]         irq_en_q, irq_en_d, irq_st_q, irq_st_d, irq_src_c;
  logic               irq_q, irq_d, irq_wr_c;
`endif

  wire unused_ok = &{1'b0, wb_adr_i[31:7], wb_adr_i[1:0], in_asm_q[31:0]};

  // A beat is decoded once; the registered ack/err blocks re-decode while stb lingers.
  assign wb_req_c    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign adr_c       = wb_adr_i[6:2];
  assign in_full_c   = (in_cnt_q == ICW'(IN_DEPTH));
  assign in_empty_c  = (in_cnt_q == '0);
  assign out_full_c  = (out_cnt_q == OCW'(OUT_DEPTH));
  assign out_empty_c = (out_cnt_q == '0);
  assign in_pop_c    = ~in_empty_c & in_ready;
  assign out_head_c  = out_mem_q[out_rptr_q];
  assign out_word_c  = out_head_c[{out_rcnt_q, 5'd0} +: 32];

  always_comb begin
    for (int b = 0; b < 4; b++) bmask_c[8*b +: 8] = {8{wb_sel_i[b]}};
  end

  assign status_c = {21'd0, unf_q, ovf_q, tag_rdy_q, out_empty_c, out_full_c,
                     in_empty_c, in_full_c, (core_state != 3'd0), core_state};
  assign ctrl_c   = {16'd0, 1'b0, data_len_q, ad_len_q, mode_q, 1'b0};

  always_comb begin
    ack_d         = 1'b0;
    err_d         = 1'b0;
    dat_d         = '0;
    start_d       = 1'b0;
    mode_d        = mode_q;
    ad_len_d      = ad_len_q;
    data_len_d    = data_len_q;
    key_d         = key_q;
    nonce_d       = nonce_q;
    tag_d         = tag_q;
    tag_rdy_d     = tag_rdy_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    in_mem_d      = in_mem_q;
    in_wptr_d     = in_wptr_q;
    in_rptr_d     = in_rptr_q;
    in_cnt_d      = in_cnt_q;
    in_asm_d      = in_asm_q;
    in_wcnt_d     = in_wcnt_q;
    out_mem_d     = out_mem_q;
    out_wptr_d    = out_wptr_q;
    out_rptr_d    = out_rptr_q;
    out_cnt_d     = out_cnt_q;
    out_rcnt_d    = out_rcnt_q;
    err_c         = 1'b0;
    flush_c       = 1'b0;
    rdata_c       = '0;
    widx_c        = '0;
    in_push_c     = 1'b0;
    in_push_blk_c = '0;
    out_pop_c     = 1'b0;
    out_push_c    = 1'b0;

    if (wb_req_c) begin
      case (adr_c) inside
        5'd0: rdata_c = status_c;
        5'd1: begin
          if (wb_we_i) begin
            if (wb_sel_i[0]) begin
              mode_d   = wb_dat_i[2:1];
              ad_len_d = wb_dat_i[7:3];
              start_d  = wb_dat_i[0] & (core_state == 3'd0);
            end
            if (wb_sel_i[1]) begin
              data_len_d = wb_dat_i[14:8];
              flush_c    = wb_dat_i[15];
            end
          end else begin
            rdata_c = ctrl_c;
          end
        end
        [5'd2:5'd5]: begin
          widx_c = 2'(adr_c - 5'd2);
          if (wb_we_i)
            key_d[{widx_c, 5'd0} +: 32] = (key_q[{widx_c, 5'd0} +: 32] & ~bmask_c) | (wb_dat_i & bmask_c);
          else
            rdata_c = key_q[{widx_c, 5'd0} +: 32];
        end
        [5'd6:5'd9]: begin
          widx_c = 2'(adr_c - 5'd6);
          if (wb_we_i)
            nonce_d[{widx_c, 5'd0} +: 32] = (nonce_q[{widx_c, 5'd0} +: 32] & ~bmask_c) | (wb_dat_i & bmask_c);
          else
            rdata_c = nonce_q[{widx_c, 5'd0} +: 32];
        end
        [5'd10:5'd13]: begin
          widx_c = 2'(adr_c - 5'd10);
          if (!wb_we_i) begin
            rdata_c = tag_q[{widx_c, 5'd0} +: 32];
            if (adr_c == 5'd13) tag_rdy_d = 1'b0;
          end
        end
        5'd14: begin
          // Shift words in low-first; the last word of a block completes the push.
          if (wb_we_i) begin
            if (in_wcnt_q == WCW'(WPB - 1)) begin
              if (in_full_c && !in_pop_c) begin
                err_c = 1'b1;
              end else begin
                in_push_c     = 1'b1;
                in_push_blk_c = {wb_dat_i, in_asm_q[BLOCK_W-1:32]};
                in_wcnt_d     = '0;
              end
            end else begin
              in_asm_d  = {wb_dat_i, in_asm_q[BLOCK_W-1:32]};
              in_wcnt_d = in_wcnt_q + WCW'(1);
            end
          end
        end
        5'd15: begin
          if (!wb_we_i) begin
            if (out_empty_c) begin
              err_c = 1'b1;
              unf_d = 1'b1;
            end else begin
              rdata_c = out_word_c;
              if (out_rcnt_q == WCW'(WPB - 1)) begin
                out_pop_c  = 1'b1;
                out_rcnt_d = '0;
              end else begin
                out_rcnt_d = out_rcnt_q + WCW'(1);
              end
            end
          end
        end
`ifdef ASCON_REGIF_IRQ_EN
        5'd17: rdata_c = {12'd0, irq_st_q, 12'd0, irq_en_q};
`endif
        default: rdata_c = '0;
      endcase
      ack_d = ~err_c;
      err_d = err_c;
      dat_d = rdata_c & bmask_c;
    end

    if (ct_valid) begin
      if (!out_full_c || out_pop_c) out_push_c = 1'b1;
      else                          ovf_d      = 1'b1;
    end

    if (tag_valid) begin
      tag_d     = tag;
      tag_rdy_d = 1'b1;
    end

    if (in_pop_c) in_rptr_d = in_rptr_q + IAW'(1);
    if (in_push_c) begin
      in_mem_d[in_wptr_q] = in_push_blk_c;
      in_wptr_d           = in_wptr_q + IAW'(1);
    end
    case ({in_push_c, in_pop_c})
      2'b10:   in_cnt_d = in_cnt_q + ICW'(1);
      2'b01:   in_cnt_d = in_cnt_q - ICW'(1);
      default: in_cnt_d = in_cnt_q;
    endcase

    if (out_pop_c) out_rptr_d = out_rptr_q + OAW'(1);
    if (out_push_c) begin
      out_mem_d[out_wptr_q] = ct_blk;
      out_wptr_d            = out_wptr_q + OAW'(1);
    end
    case ({out_push_c, out_pop_c})
      2'b10:   out_cnt_d = out_cnt_q + OCW'(1);
      2'b01:   out_cnt_d = out_cnt_q - OCW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    // Flush wins over any same-cycle FIFO traffic.
    if (flush_c) begin
      in_wptr_d  = '0;
      in_rptr_d  = '0;
      in_cnt_d   = '0;
      in_asm_d   = '0;
      in_wcnt_d  = '0;
      out_wptr_d = '0;
      out_rptr_d = '0;
      out_cnt_d  = '0;
      out_rcnt_d = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      start_q    <= 1'b0;
      mode_q     <= '0;
      ad_len_q   <= '0;
      data_len_q <= '0;
      key_q      <= '0;
      nonce_q    <= '0;
      tag_q      <= '0;
      tag_rdy_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      for (int i = 0; i < int'(IN_DEPTH); i++) in_mem_q[i] <= '0;
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      in_cnt_q   <= '0;
      in_asm_q   <= '0;
      in_wcnt_q  <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) out_mem_q[i] <= '0;
      out_wptr_q <= '0;
      out_rptr_q <= '0;
      out_cnt_q  <= '0;
      out_rcnt_q <= '0;
    end else begin
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      start_q    <= start_d;
      mode_q     <= mode_d;
      ad_len_q   <= ad_len_d;
      data_len_q <= data_len_d;
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      tag_q      <= tag_d;
      tag_rdy_q  <= tag_rdy_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      in_mem_q   <= in_mem_d;
      in_wptr_q  <= in_wptr_d;
      in_rptr_q  <= in_rptr_d;
      in_cnt_q   <= in_cnt_d;
      in_asm_q   <= in_asm_d;
      in_wcnt_q  <= in_wcnt_d;
      out_mem_q  <= out_mem_d;
      out_wptr_q <= out_wptr_d;
      out_rptr_q <= out_rptr_d;
      out_cnt_q  <= out_cnt_d;
      out_rcnt_q <= out_rcnt_d;
    end
  end

`ifdef ASCON_REGIF_IRQ_EN
  // Sticky status: level sources keep re-setting their bit until the condition clears.
  always_comb begin
    irq_wr_c  = wb_req_c & wb_we_i & (adr_c == 5'd17);
    irq_en_d  = irq_en_q;
    irq_st_d  = irq_st_q;
    irq_src_c = {(ovf_d & ~ovf_q) | (unf_d & ~unf_q),
                 (in_cnt_d != ICW'(IN_DEPTH)),
                 (out_cnt_d != '0),
                 (tag_rdy_d & ~tag_rdy_q)};
    if (irq_wr_c && wb_sel_i[0]) irq_en_d = wb_dat_i[3:0];
    if (irq_wr_c && wb_sel_i[2]) irq_st_d = irq_st_q & ~wb_dat_i[19:16];
    irq_st_d = irq_st_d | irq_src_c;
    irq_d    = |(irq_st_d & irq_en_d);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_en_q <= '0;
      irq_st_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_st_q <= irq_st_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o = irq_q;
`endif

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  assign start    = start_q;
  assign mode     = mode_q;
  assign ad_len   = ad_len_q;
  assign data_len = data_len_q;
  assign key      = key_q;
  assign nonce    = nonce_q;
  assign in_valid = ~in_empty_c;
  assign in_blk   = in_empty_c ? '0 : in_mem_q[in_rptr_q];

endmodule

// File: tb/tb_wb_ascon_fifo_regif.sv
// Scoreboard bench for wb_ascon_fifo_regif (BLOCK_W=64, depths 4); covers the IRQ register when ASCON_REGIF_IRQ_EN is defined.
module tb_wb_ascon_fifo_regif;

  localparam int unsigned BLOCK_W = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [31:0]        adr = '0, wdat = '0;
  logic [3:0]         sel = '0;
  logic               we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic               wb_ack_o, wb_err_o;
  logic [31:0]        wb_dat_o;
  logic [2:0]         core_state = '0;
  logic               start;
  logic [1:0]         mode;
  logic [4:0]         ad_len;
  logic [6:0]         data_len;
  logic [127:0]       key, nonce;
  logic [BLOCK_W-1:0] in_blk;
  logic               in_valid;
  logic               in_ready = 1'b0;
  logic [BLOCK_W-1:0] ct_blk = '0;
  logic               ct_valid = 1'b0;
  logic [127:0]       tag = '0;
  logic               tag_valid = 1'b0;
`ifdef ASCON_REGIF_IRQ_EN
  logic               irq_o;
`endif

  wb_ascon_fifo_regif #(.BLOCK_W(BLOCK_W), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_dat_o(wb_dat_o), .core_state(core_state), .start(start), .mode(mode), .ad_len(ad_len),
    .data_len(data_len), .key(key), .nonce(nonce), .in_blk(in_blk), .in_valid(in_valid),
    .in_ready(in_ready), .ct_blk(ct_blk), .ct_valid(ct_valid), .tag(tag), .tag_valid(tag_valid)
`ifdef ASCON_REGIF_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    logic        chk;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   passed = 0, total = 0, beat_id = 0, start_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Monitor: every ack/err pops one expected response.
  always @(negedge clk) begin
    if (wb_ack_o || wb_err_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {wb_ack_o, wb_err_o}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("beat%0d_err", mon_e.id), wb_err_o, mon_e.err);
        if (mon_e.chk) check($sformatf("beat%0d_dat", mon_e.id), wb_dat_o, mon_e.dat);
      end
    end
    if (start) start_cnt++;
  end

  task automatic wb(input logic w, input int word, input logic [31:0] d, input logic [3:0] s,
                    input logic eerr, input logic [31:0] edat, input logic chk, input logic hold);
    exp_t e;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = 32'(word) << 2; wdat = d; sel = s;
    e.err = eerr; e.dat = edat; e.chk = chk; e.id = beat_id;
    exp_q.push_back(e);
    beat_id++;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      @(posedge clk);
      @(negedge clk);
      check("ack_single_cycle", {wb_ack_o, wb_err_o}, 2'b00);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int word, input logic [31:0] edat);
    wb(1'b0, word, 32'd0, 4'hF, 1'b0, edat, 1'b1, 1'b0);
  endtask

  task automatic wr(input int word, input logic [31:0] d, input logic [3:0] s, input logic eerr);
    wb(1'b1, word, d, s, eerr, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic drain(input logic [BLOCK_W-1:0] eblk);
    @(negedge clk);
    check("in_valid", in_valid, 1'b1);
    check("in_blk", in_blk, eblk);
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
  endtask

  task automatic ct_push(input logic [BLOCK_W-1:0] b);
    @(negedge clk);
    ct_blk = b; ct_valid = 1'b1;
    @(negedge clk);
    ct_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack", {wb_ack_o, wb_err_o}, 2'b00);
    check("rst_start", start, 1'b0);
    check("rst_in_valid", in_valid, 1'b0);
    check("rst_in_blk", in_blk, 64'd0);

    // Reset register values and single-cycle ack
    wb(1'b0, 0, 32'd0, 4'hF, 1'b0, 32'h0A0, 1'b1, 1'b1);
    rd(1, 32'h0);
    wb(1'b0, 0, 32'd0, 4'b0010, 1'b0, 32'h0, 1'b1, 1'b0);
    wb(1'b0, 0, 32'd0, 4'b0001, 1'b0, 32'hA0, 1'b1, 1'b0);

    // Key / nonce byte masking
    wr(2, 32'h11223344, 4'hF, 1'b0);
    wr(2, 32'hAABBCCDD, 4'b0101, 1'b0);
    rd(2, 32'h11BB33DD);
    wr(9, 32'hCAFEBABE, 4'hF, 1'b0);
    rd(9, 32'hCAFEBABE);
    check("key_lo", key[31:0], 32'h11BB33DD);
    check("nonce_hi", nonce[127:96], 32'hCAFEBABE);

    // One block through the input FIFO
    wr(14, 32'h11111111, 4'hF, 1'b0);
    wr(14, 32'h22222222, 4'hF, 1'b0);
    drain(64'h2222222211111111);
    @(negedge clk);
    check("in_empty_after_pop", in_valid, 1'b0);
    rd(0, 32'h0A0);

    // Fill input FIFO, overflow the last word, then drain in order
    for (int k = 0; k < 4; k++) begin
      wr(14, 32'hA0000000 | 32'(k), 4'hF, 1'b0);
      wr(14, 32'hB0000000 | 32'(k), 4'hF, 1'b0);
    end
    rd(0, 32'h090);
    wr(14, 32'hA0000004, 4'hF, 1'b0);
    wr(14, 32'hB0000004, 4'hF, 1'b1);
    rd(0, 32'h090);
    for (int k = 0; k < 4; k++) drain({32'hB0000000 | 32'(k), 32'hA0000000 | 32'(k)});
    wr(14, 32'hC0000005, 4'hF, 1'b0);
    drain(64'hC0000005A0000004);

    // Output FIFO read-out and underflow
    ct_push(64'hDEADBEEFCAFEF00D);
    rd(0, 32'h020);
    rd(15, 32'hCAFEF00D);
    rd(15, 32'hDEADBEEF);
    wb(1'b0, 15, 32'd0, 4'hF, 1'b1, 32'd0, 1'b1, 1'b0);
    rd(0, 32'h4A0);

    // Output overflow: fifth block dropped
    for (int k = 0; k < 5; k++) ct_push({32'h50000000 | 32'(k), 32'h40000000 | 32'(k)});
    rd(0, 32'h660);
    for (int k = 0; k < 4; k++) begin
      rd(15, 32'h40000000 | 32'(k));
      rd(15, 32'h50000000 | 32'(k));
    end
    rd(0, 32'h6A0);

    // Flush clears sticky flags, FIFOs and a half-filled assembler
    ct_push(64'h1);
    wr(14, 32'h77777777, 4'hF, 1'b0);
    wr(1, 32'h00008000, 4'hF, 1'b0);
    rd(0, 32'h0A0);
    wr(14, 32'h33333333, 4'hF, 1'b0);
    wr(14, 32'h44444444, 4'hF, 1'b0);
    drain(64'h4444444433333333);

    // Start pulse, field decode, busy suppression
    wr(1, 32'h00000A09, 4'hF, 1'b0);
    rd(1, 32'h0A08);
    check("start_pulse_cycles", start_cnt, 1);
    check("mode", mode, 2'd0);
    check("ad_len", ad_len, 5'd1);
    check("data_len", data_len, 7'h0A);
    core_state = 3'd1;
    rd(0, 32'h0A9);
    wr(1, 32'h00000A09, 4'hF, 1'b0);
    rd(1, 32'h0A08);
    check("start_ignored_busy", start_cnt, 1);
    core_state = 3'd0;

    // Tag capture, readout, tag_rdy clear
`ifdef ASCON_REGIF_IRQ_EN
    wr(17, 32'h000F0001, 4'hF, 1'b0);
    @(negedge clk);
    check("irq_idle", irq_o, 1'b0);
`else
    rd(17, 32'h0);
`endif
    @(negedge clk);
    tag = 128'h01234567_00112233_44556677_89ABCDEF;
    tag_valid = 1'b1;
    @(negedge clk);
    tag_valid = 1'b0;
`ifdef ASCON_REGIF_IRQ_EN
    check("irq_after_tag", irq_o, 1'b1);
`endif
    rd(0, 32'h1A0);
    rd(10, 32'h89ABCDEF);
    rd(11, 32'h44556677);
    rd(12, 32'h00112233);
    rd(13, 32'h01234567);
    rd(0, 32'h0A0);

    // Unmapped words
    wr(20, 32'hFFFFFFFF, 4'hF, 1'b0);
    rd(20, 32'h0);
    rd(31, 32'h0);

    // Reset during a beat: no ack, FIFO cleared
    wr(14, 32'h55555555, 4'hF, 1'b0);
    wr(14, 32'h66666666, 4'hF, 1'b0);
    @(negedge clk);
    check("pre_rst_in_valid", in_valid, 1'b1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd14 << 2; wdat = 32'h12345678; sel = 4'hF;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_no_ack", {wb_ack_o, wb_err_o}, 2'b00);
    check("rst_mid_in_valid", in_valid, 1'b0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    rd(0, 32'h0A0);
    rd(1, 32'h0);
    check("rst_key", key, 128'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
